// File: rtl/rv_pkg.sv
// Shared RV32I definitions: base opcodes, instruction-class enum, field bundle and encoder helpers.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    CLS_R      = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } cls_e;

  typedef struct packed {
    cls_e        cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [12:0] imm;
  } fields_t;

  function automatic logic [31:0] encode(input fields_t f);
    logic [31:0] w;
    case (f.cls)
      CLS_R:      w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, OP_R};
      CLS_LOAD:   w = {f.imm[11:0], f.rs1, f.funct3, f.rd, OP_LOAD};
      CLS_STORE:  w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], OP_STORE};
      default:    w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                       f.imm[4:1], f.imm[11], OP_BRANCH};
    endcase
    return w;
  endfunction

  // LOAD/STORE must fit in 12 signed bits; branch targets must be halfword aligned.
  function automatic logic imm_bad(input fields_t f);
    logic b;
    case (f.cls)
      CLS_LOAD, CLS_STORE: b = (f.imm[12] != f.imm[11]);
      CLS_BRANCH:          b = f.imm[0];
      default:             b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input and address/data output handshakes of the instruction encoder.
interface instr_encoder_if;
  import rv_pkg::*;

  logic        in_valid;
  logic        in_ready;
  cls_e        in_class;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [12:0] in_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_addr, out_data
  );

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_addr, out_data
  );

endinterface

// File: rtl/instr_fifo.sv
// DEPTH x 32 synchronous FIFO; pointers carry an extra wrap bit so count spans 0..DEPTH.
module instr_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [AW:0]   count
);

  logic [DEPTH-1:0][31:0] mem;
  logic [AW:0]            wptr, rptr;

  // Storage is reset too so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I R/LOAD/STORE/BRANCH encoder feeding a word FIFO with an address counter.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
  import rv_pkg::*;
#(
  parameter  int          DEPTH     = 4,
  parameter  logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int          CW        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  instr_encoder_if.slave   bus,
  output logic [CW-1:0]    count,
  output logic             imm_err
);

  fields_t     f;
  logic        accept, push, pop, bad;
  logic [31:0] addr;

  assign f = '{cls:    bus.in_class,
               rd:     bus.in_rd,
               rs1:    bus.in_rs1,
               rs2:    bus.in_rs2,
               funct3: bus.in_funct3,
               funct7: bus.in_funct7,
               imm:    bus.in_imm};

  // No bypass: a full FIFO refuses input even when it is popping this cycle.
  assign bus.in_ready  = (count < CW'(DEPTH)) & ~restart;
  assign bus.out_valid = (count != '0);
  assign accept        = bus.in_valid & bus.in_ready;
  assign push          = accept & ~bad;
  assign pop           = bus.out_valid & bus.out_ready & ~restart;

`ifdef IMM_RANGE_CHECK_EN
  assign bad = imm_bad(f);

  // Rejected bundles still complete the handshake; only the sticky flag records them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                imm_err <= 1'b0;
    else if (restart)         imm_err <= 1'b0;
    else if (accept && bad)   imm_err <= 1'b1;
  end
`else
  assign bad     = 1'b0;
  assign imm_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        addr <= BASE_ADDR;
    else if (restart) addr <= BASE_ADDR;
    else if (pop)     addr <= addr + 32'd4;
  end

  assign bus.out_addr = addr;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (restart),
    .push  (push),
    .pop   (pop),
    .wdata (encode(f)),
    .rdata (bus.out_data),
    .count (count)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;
  import rv_pkg::*;

  logic       clk = 1'b0;
  logic       reset, restart;
  logic [2:0] count;
  logic       imm_err;
  int         checks = 0;
  int         errors = 0;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .bus     (bus),
    .count   (count),
    .imm_err (imm_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input cls_e c, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [12:0] imm);
    bus.in_class  = c;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
  endtask

  logic [31:0] w5 [5] = '{32'h0000_00B3, 32'h0000_0133, 32'h0000_01B3,
                          32'h0000_0233, 32'h0000_02B3};

  initial begin
    #50000;
    $display("FAIL timeout: got stuck want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; restart = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    put(CLS_R, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_addr",  bus.out_addr, 32'h0);
    chk("rst_data",  bus.out_data, 32'h0);
    chk("rst_err",   imm_err, 0);
    @(negedge clk); reset = 1'b0; #1;
    chk("rdy_after_rst", bus.in_ready, 1);

    // add x3,x1,x2 : one-cycle latency from empty
    put(CLS_R, 3, 1, 2, 0, 0, 0);
    step(); bus.in_valid = 1'b0;
    chk("add_valid", bus.out_valid, 1);
    chk("add_data",  bus.out_data, 32'h0020_81B3);
    chk("add_addr",  bus.out_addr, 32'h0);
    chk("add_cnt",   count, 1);
    bus.out_ready = 1'b1;
    step();
    chk("add_pop_cnt",  count, 0);
    chk("add_pop_addr", bus.out_addr, 32'h4);
    bus.out_ready = 1'b0; restart = 1'b1;
    step(); restart = 1'b0;
    chk("restart_addr", bus.out_addr, 32'h0);

    // lw x5,8(x2) then sw x6,12(x2); ignored fields set to junk
    bus.out_ready = 1'b1;
    put(CLS_LOAD, 5, 2, 31, 2, 7'h7F, 13'd8);
    step();
    chk("lw_data", bus.out_data, 32'h0081_2283);
    chk("lw_addr", bus.out_addr, 32'h0);
    put(CLS_STORE, 31, 2, 6, 2, 7'h7F, 13'd12);
    step(); bus.in_valid = 1'b0;
    chk("sw_data", bus.out_data, 32'h0061_2623);
    chk("sw_addr", bus.out_addr, 32'h4);
    chk("pushpop_cnt", count, 1);
    step();
    chk("lwsw_drain_cnt",  count, 0);
    chk("lwsw_drain_addr", bus.out_addr, 32'h8);

    // beq x1,x2,-8
    bus.out_ready = 1'b0;
    put(CLS_BRANCH, 0, 1, 2, 0, 0, 13'h1FF8);
    step(); bus.in_valid = 1'b0;
    chk("beq_data", bus.out_data, 32'hFE20_8CE3);
    chk("beq_addr", bus.out_addr, 32'h8);
    bus.out_ready = 1'b1;
    step();
    chk("beq_pop_cnt", count, 0);

`ifndef IMM_RANGE_CHECK_EN
    bus.out_ready = 1'b0;
    put(CLS_BRANCH, 9, 1, 2, 0, 0, 13'h1FF9);
    step(); bus.in_valid = 1'b0;
    chk("beq_odd_data", bus.out_data, 32'hFE20_8CE3);
    chk("beq_odd_addr", bus.out_addr, 32'hC);
    put(CLS_LOAD, 5, 2, 0, 2, 0, 13'h0800);
    step(); bus.in_valid = 1'b0;
    chk("lw_wide_cnt", count, 2);
    bus.out_ready = 1'b1;
    step();
    chk("lw_wide_data", bus.out_data, 32'h8001_2283);
    chk("lw_wide_addr", bus.out_addr, 32'h10);
    step();
    chk("nochk_err", imm_err, 0);
`else
    bus.out_ready = 1'b0;
    put(CLS_LOAD, 5, 2, 0, 2, 0, 13'h0800);
    #1 chk("lw_big_rdy", bus.in_ready, 1);
    step(); bus.in_valid = 1'b0;
    chk("lw_big_cnt",  count, 0);
    chk("lw_big_err",  imm_err, 1);
    chk("lw_big_addr", bus.out_addr, 32'hC);
    restart = 1'b1;
    step(); restart = 1'b0;
    chk("err_clr", imm_err, 0);
    put(CLS_BRANCH, 9, 1, 2, 0, 0, 13'h1FF9);
    step(); bus.in_valid = 1'b0;
    chk("beq_odd_cnt", count, 0);
    chk("beq_odd_err", imm_err, 1);
    put(CLS_STORE, 0, 2, 6, 2, 0, 13'h17FF);
    step(); bus.in_valid = 1'b0;
    chk("sw_neg_ok_cnt", count, 0);
    put(CLS_STORE, 0, 2, 6, 2, 0, 13'h1800);
    step(); bus.in_valid = 1'b0;
    chk("sw_min_cnt",  count, 1);
    chk("sw_min_data", bus.out_data, 32'h8061_2023);
    put(CLS_R, 3, 1, 2, 0, 0, 13'h0800);
    step(); bus.in_valid = 1'b0;
    chk("r_imm_cnt", count, 2);
`endif
    restart = 1'b1;
    step(); restart = 1'b0;
    chk("restart2_addr", bus.out_addr, 32'h0);
    chk("restart2_cnt",  count, 0);

    // sub a0,a1,a2
    bus.out_ready = 1'b0;
    put(CLS_R, 10, 11, 12, 0, 7'h20, 0);
    step();
    // accept attempted in a restart cycle must be dropped
    restart = 1'b1; #1;
    chk("sub_data", bus.out_data, 32'h40C5_8533);
    chk("rs_inrdy", bus.in_ready, 0);
    step(); restart = 1'b0; bus.in_valid = 1'b0;
    chk("rs_drop_cnt",   count, 0);
    chk("rs_drop_valid", bus.out_valid, 0);

    // fill past DEPTH with consumer stalled
    for (int i = 0; i < 4; i++) begin
      put(CLS_R, 5'(i + 1), 0, 0, 0, 0, 0);
      #1 chk("fill_rdy", bus.in_ready, 1);
      step();
    end
    chk("full_cnt", count, 4);
    chk("full_rdy", bus.in_ready, 0);
    put(CLS_R, 5, 0, 0, 0, 0, 0);
    step();
    chk("held_cnt", count, 4);
    bus.out_ready = 1'b1;
    chk("head0_data", bus.out_data, w5[0]);
    chk("head0_addr", bus.out_addr, 32'h0);
    step();
    chk("nobypass_cnt", count, 3);
    chk("head1_data",   bus.out_data, w5[1]);
    chk("head1_addr",   bus.out_addr, 32'h4);
    chk("refill_rdy",   bus.in_ready, 1);
    step(); bus.in_valid = 1'b0;
    chk("pp_full_cnt", count, 3);
    for (int k = 2; k < 5; k++) begin
      chk("drain_data", bus.out_data, w5[k]);
      chk("drain_addr", bus.out_addr, 32'(4 * k));
      step();
    end
    chk("drained_cnt", count, 0);

    // async reset with three words buffered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(CLS_R, 5'(i + 1), 0, 0, 0, 0, 0);
      step();
    end
    bus.in_valid = 1'b0;
    chk("pre_arst_cnt", count, 3);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_cnt",   count, 0);
    chk("arst_addr",  bus.out_addr, 32'h0);
    chk("arst_data",  bus.out_data, 32'h0);
    @(negedge clk); reset = 1'b0;
    step();
    chk("post_arst_rdy", bus.in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: the inverse of the opcode decoder in the control path. It accepts decoded instruction fields (class, registers, funct, immediate) over a valid/ready handshake. It packs them into 32-bit R/LOAD/STORE/BRANCH instruction words and buffers them in a small FIFO. The words are emitted as address/data beats for loading instruction memory; the block is used by the program loader and by the testbench stimulus generator.

## Interface
- DEPTH, 4, FIFO entries; power of 2, ≥2
- BASE_ADDR, 32'h0000_0000, byte address of first emitted word after reset/restart
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- restart  in  1  sync; flush FIFO, reload address, clear error
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept bundle
- in_class  in  2  0=R(0110011), 1=LOAD(0000011), 2=STORE(0100011), 3=BRANCH(1100011)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3
- in_funct7  in  7  used by R only
- in_imm  in  13  signed immediate; LOAD/STORE use [11:0], BRANCH uses [12:0]
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts word
- out_addr  out  32  byte address of current word
- out_data  out  32  encoded instruction
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- imm_err  out  1  sticky immediate-range error

## Operation
- Encoding (combinational at input, written into FIFO on accept):
  - R: funct7|rs2|rs1|funct3|rd|0110011
  - LOAD: imm[11:0]|rs1|funct3|rd|0000011 (rs2, funct7 ignored)
  - STORE: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011 (rd ignored)
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011 (rd ignored)
- Accept = in_valid & in_ready. in_ready = (count < DEPTH) & ~restart. No bypass: a full FIFO refuses input even if a pop occurs that cycle.
- Pop = out_valid & out_ready. out_valid = (count != 0). out_data/out_addr are the FIFO head and must hold stable while out_valid & ~out_ready.
- out_addr starts at BASE_ADDR and advances by 4 on each pop, wrapping modulo 2^32.
- Simultaneous push and pop (not full): count unchanged, order preserved.
- restart: FIFO emptied, out_addr←BASE_ADDR, imm_err←0 on that edge. Any accept or pop in the same cycle is discarded (in_ready already low).
- Reset: out_valid 0, out_data 0, out_addr BASE_ADDR, count 0, imm_err 0; in_ready 1 once reset deasserts. Reset mid-stream discards all buffered words.

## Timing
- Accept at edge N → word visible at out_data with out_valid=1 after edge N (1-cycle latency) when FIFO was empty.
- Throughput: one accept and one pop per cycle sustained.
- imm_err rises on the edge following the offending accept.

## Configuration
- IMM_RANGE_CHECK_EN defined: a LOAD/STORE with in_imm outside [-2048, 2047] is rejected, as is a BRANCH with in_imm[0]=1. Either case completes the handshake but pushes nothing (count, out_addr unaffected) and sets imm_err. R ignores in_imm.
- Undefined: no check; LOAD/STORE use in_imm[11:0], BRANCH ignores in_imm[0]; imm_err tied 0.

## Structure
- Shared package rv_pkg: opcode constants (OP_R, OP_LOAD, OP_STORE, OP_BRANCH) and the 2-bit instruction-class enum, shared with the decoder.
- One sub-module: instr_fifo (synchronous FIFO, DEPTH×32, pointer wrap with extra MSB, count output). The encoder, address counter and error flag live in the top.

## Test plan
- R add x3,x1,x2 (class0, rd3, rs1 1, rs2 2, f3 0, f7 0) → out_data 0x002081B3, out_addr 0x0 one cycle later.
- LOAD lw x5,8(x2) then STORE sw x6,12(x2), out_ready=1 → 0x00812283 @0x0, 0x00612623 @0x4.
- BRANCH beq x1,x2,-8 (imm 13'h1FF8) → 0xFE208CE3.
- out_ready=0, push 5 words with DEPTH=4 → in_ready drops after 4th, count=4, 5th held; raise out_ready → words drain in order at addresses 0x0,0x4,0x8,0xC,0x10.
- IMM_RANGE_CHECK_EN: LOAD imm 13'h0800 (+2048) → handshake completes, count stays 0, imm_err=1 next cycle; restart → imm_err=0, out_addr=BASE_ADDR.
- Assert reset asynchronously with 3 words buffered → out_valid, count immediately 0; out_addr=BASE_ADDR.
